// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes,
// FSM state encoding and the access-fault rule.
package dmem_pkg;

  // Load width codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True when the request must fault: misaligned, out of range,
  // reserved width code, or an unsigned code used for a store.
  function automatic logic access_fault(input logic        we,
                                        input logic [31:0] addr,
                                        input logic [2:0]  funct3,
                                        input int unsigned depth_words);
    logic f;
    unique case (funct3)
      F3_LB:   f = 1'b0;
      F3_LH:   f = addr[0];
      F3_LW:   f = (addr[1:0] != 2'b00);
      F3_LBU:  f = we;
      F3_LHU:  f = we | addr[0];
      default: f = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= depth_words) f = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write,
// asynchronous read.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write; untouched lanes keep their contents.
  // NOTE: storage deliberately has no reset so it maps onto RAM macros;
  // contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits a fixed
// number of cycles, performs the access and holds the response until taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        enter_resp;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [2:0]  acc_funct3;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic [31:0] mem_rdata;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic        mem_we;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state, wait counter and request capture.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          if (WAIT_STATES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The access uses the live request when it happens on the acceptance
  // edge (no wait states), otherwise the captured one.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we     = req_we;
      acc_addr   = req_addr;
      acc_funct3 = req_funct3;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = we_q;
      acc_addr   = addr_q;
      acc_funct3 = funct3_q;
      acc_wdata  = wdata_q;
    end
    acc_err = access_fault(acc_we, acc_addr, acc_funct3, DEPTH_WORDS);
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    shifted = mem_rdata >> {acc_addr[1:0], 3'b000};
    unique case (acc_funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      F3_LW:   load_data = mem_rdata;
      default: load_data = 32'd0;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    store_be   = 4'b0000;
    store_data = acc_wdata;
    unique case (acc_funct3)
      F3_SB: begin
        store_be   = 4'b0001 << acc_addr[1:0];
        store_data = {4{acc_wdata[7:0]}};
      end
      F3_SH: begin
        store_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{acc_wdata[15:0]}};
      end
      F3_SW:   store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
    // The commit is gated by rst so a store pending at reset is dropped.
    mem_we = enter_resp & acc_we & ~acc_err & ~rst;
  end

  // Response payload is captured on the edge that enters RESP and held.
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || acc_we) ? 32'd0 : load_data;
    end
  end

  // State and response registers with asynchronous reset.
  // NOTE: non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      funct3_q    <= 3'd0;
      wdata_q     <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (store_be),
    .waddr (acc_addr[AW+1:2]),
    .wdata (store_data),
    .raddr (acc_addr[AW+1:2]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (1 and 3 wait states) checked
// against a byte-addressed behavioural memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int WS0   = 1;
  localparam int WS1   = 3;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mb [2][DEPTH*4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_STATES ((g == 0) ? WS0 : WS1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_funct3 (req_funct3[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  function automatic int ws(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  // Behavioural model: byte-addressed little-endian memory.
  function automatic void model_access(input int k, input logic we, input logic [31:0] addr,
                                       input logic [2:0] f3, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
    int size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    err  = (f3[1:0] == 2'd3) || (f3[2] && (we || size == 4)) ||
           ((addr % size) != 0) || ((addr >> 2) >= DEPTH);
    rd = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mb[k][addr + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | ({24'd0, mb[k][addr + i]} << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
        rd = v;
      end
    end
  endfunction

  // One complete transaction; returns observed data and cycles from
  // acceptance edge to the first edge seeing rsp_valid (-1 on timeout).
  task automatic xact(input int k, input logic we, input logic [31:0] addr,
                      input logic [2:0] f3, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat,
                      output logic [31:0] m_rd, output logic m_err);
    int cyc;
    model_access(k, we, addr, f3, wd, m_rd, m_err);
    @(negedge clk);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
    req_funct3[k] = f3;  req_wdata[k] = wd; rsp_ready[k] = 1'b1;
    cyc = 0;
    while (!req_ready[k] && cyc < 40) begin @(negedge clk); cyc++; end
    @(posedge clk);
    @(negedge clk);
    req_valid[k] = 1'b0;
    cyc = 0;
    while (!rsp_valid[k] && cyc < 40) begin @(posedge clk); cyc++; @(negedge clk); end
    lat = rsp_valid[k] ? cyc + 1 : -1;
    rd  = rsp_rdata[k];
    err = rsp_err[k];
    @(posedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_funct3[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 32'd0 || rsp_err[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got valid=%b rdata=%h err=%b want 0/0/0",
                 k, rsp_valid[k], rsp_rdata[k], rsp_err[k]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (req_ready[k] !== 1'b1) begin
        n_bad++; $display("FAIL ready_after_reset[%0d]: got %b want 1", k, req_ready[k]);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] rd, m_rd; logic err, m_err; int lat;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) begin
        xact(k, 1'b1, 32'(w*4), F3_SW, $urandom, rd, err, lat, m_rd, m_err);
        n_vec++;
        if (err !== 1'b0 || rd !== 32'd0 || lat != ws(k) + 1) begin
          n_bad++;
          $display("FAIL fill[%0d] w%0d: got err=%b rd=%h lat=%0d want 0/0/%0d",
                   k, w, err, rd, lat, ws(k) + 1);
        end
      end
    end
  endtask

  task automatic test_directed();
    vec_t tbl[19];
    logic [31:0] rd, m_rd; logic err, m_err; int lat;
    tbl = '{
      '{1'b1, F3_SW,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, F3_LW,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b0, F3_LB,  32'h13,   32'h0,        32'hFFFFFFDE, 1'b0},
      '{1'b0, F3_LBU, 32'h13,   32'h0,        32'h000000DE, 1'b0},
      '{1'b0, F3_LH,  32'h12,   32'h0,        32'hFFFFDEAD, 1'b0},
      '{1'b0, F3_LHU, 32'h10,   32'h0,        32'h0000BEEF, 1'b0},
      '{1'b1, F3_SB,  32'h11,   32'h00000055, 32'h0,        1'b0},
      '{1'b0, F3_LW,  32'h10,   32'h0,        32'hDEAD55EF, 1'b0},
      '{1'b0, F3_LW,  32'h12,   32'h0,        32'h0,        1'b1},
      '{1'b1, F3_SH,  32'h11,   32'h0000FFFF, 32'h0,        1'b1},
      '{1'b0, F3_LW,  32'h1000, 32'h0,        32'h0,        1'b1},
      '{1'b0, F3_LW,  32'h10,   32'h0,        32'hDEAD55EF, 1'b0},
      '{1'b1, 3'b100, 32'h14,   32'h11223344, 32'h0,        1'b1},
      '{1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1},
      '{1'b0, 3'b110, 32'h10,   32'h0,        32'h0,        1'b1},
      '{1'b1, F3_SW,  32'hFFC,  32'hA5A50F0F, 32'h0,        1'b0},
      '{1'b0, F3_LW,  32'hFFC,  32'h0,        32'hA5A50F0F, 1'b0},
      '{1'b0, F3_LHU, 32'hFFE,  32'h0,        32'h0000A5A5, 1'b0},
      '{1'b0, F3_LH,  32'h13,   32'h0,        32'h0,        1'b1}
    };
    for (int i = 0; i < 19; i++) begin
      xact(0, tbl[i].we, tbl[i].addr, tbl[i].f3, tbl[i].wd, rd, err, lat, m_rd, m_err);
      n_vec++;
      if (rd !== tbl[i].rd || err !== tbl[i].err || lat != WS0 + 1) begin
        n_bad++;
        $display("FAIL directed #%0d: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                 i, rd, err, lat, tbl[i].rd, tbl[i].err, WS0 + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd, m_rd; logic err, m_err; int lat, cyc;
    model_access(0, 1'b0, 32'h10, F3_LW, 32'd0, m_rd, m_err);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    req_funct3[0] = F3_LW; rsp_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    cyc = 0;
    while (!rsp_valid[0] && cyc < 40) begin @(negedge clk); cyc++; end
    for (int c = 0; c < 5; c++) begin
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = F3_SW;
      req_addr[0] = 32'h10; req_wdata[0] = 32'h0BADF00D;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== m_rd || rsp_err[0] !== 1'b0 ||
          req_ready[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL stall cycle %0d: got valid=%b rd=%h err=%b ready=%b want 1/%h/0/0",
                 c, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0], m_rd);
      end
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(posedge clk);
    xact(0, 1'b0, 32'h10, F3_LW, 32'd0, rd, err, lat, m_rd, m_err);
    n_vec++;
    if (rd !== m_rd || err !== 1'b0) begin
      n_bad++; $display("FAIL stall_ignored_store: got rd=%h err=%b want %h/0", rd, err, m_rd);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic [31:0] m_rd; logic m_err; int guard;
    model_access(0, 1'b0, 32'h10, F3_LW, 32'd0, m_rd, m_err);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    req_funct3[0] = F3_LW; rsp_ready[0] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (req_ready[0]) acc.push_back(c);
      if (rsp_valid[0]) begin
        n_vec++;
        if (rsp_rdata[0] !== m_rd || rsp_err[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_data c%0d: got %h/%b want %h/0", c, rsp_rdata[0], rsp_err[0], m_rd);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    n_vec++;
    if (acc.size() < 9) begin
      n_bad++; $display("FAIL b2b_count: got %0d acceptances want >= 9", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_vec++;
      if (acc[i] - acc[i-1] != WS0 + 2) begin
        n_bad++;
        $display("FAIL b2b_interval #%0d: got %0d want %0d", i, acc[i] - acc[i-1], WS0 + 2);
      end
    end
    guard = 0;
    while (!(req_ready[0] && !rsp_valid[0]) && guard < 20) begin @(negedge clk); guard++; end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, m_rd; logic err, m_err; int lat;
    xact(1, 1'b0, 32'h24, F3_LW, 32'd0, rd, err, lat, m_rd, m_err);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
    req_funct3[1] = F3_SW; req_wdata[1] = 32'h12345678; rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #2 rst[1] = 1'b1;
    #1;
    n_vec++;
    if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0 || rsp_err[1] !== 1'b0 ||
        req_ready[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_wait: got valid=%b rd=%h err=%b ready=%b want 0/0/0/1",
               rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (req_ready[1] !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_mid_reset: got %b want 1", req_ready[1]);
    end
    xact(1, 1'b0, 32'h20, F3_LW, 32'd0, rd, err, lat, m_rd, m_err);
    n_vec++;
    if (rd !== m_rd || err !== 1'b0 || lat != WS1 + 1) begin
      n_bad++;
      $display("FAIL dropped_store: got rd=%h err=%b lat=%0d want %h/0/%0d",
               rd, err, lat, m_rd, WS1 + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, m_rd, addr; logic err, m_err, we; logic [2:0] f3; int lat, r;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 120; n++) begin
        r  = $urandom_range(0, 9);
        if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 255));
        else if (r == 1) addr = $urandom | 32'h8000_0000;
        else             addr = 32'($urandom_range(0, 63));
        f3 = 3'($urandom_range(0, 7));
        we = ($urandom_range(0, 9) < 4);
        xact(k, we, addr, f3, $urandom, rd, err, lat, m_rd, m_err);
        n_vec++;
        if (rd !== m_rd || err !== m_err || lat != ws(k) + 1) begin
          n_bad++;
          $display("FAIL random[%0d] #%0d we=%b f3=%b a=%h: got rd=%h err=%b lat=%0d want %h/%b/%0d",
                   k, n, we, f3, addr, rd, err, lat, m_rd, m_err, ws(k) + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024: data memory size in 32-bit words.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1: extra cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  1  memory-access stage presents a request.
REQ-006 The block SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_funct3  input  3  RV32I load/store width code.
REQ-010 The block SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-011 The block SHALL have port rsp_valid  output  1  response available.
REQ-012 The block SHALL have port rsp_ready  input  1  core consumes the response.
REQ-013 The block SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err  output  1  request faulted; no memory side effect.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 On req_valid&&req_ready at a rising edge, the block SHALL latch we, addr, funct3 and wdata, then go to WAIT with counter=WAIT_STATES-1, or directly to RESP if WAIT_STATES=0.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at 0 the block SHALL perform the access and enter RESP on that edge.
REQ-018 rsp_valid SHALL assert exactly WAIT_STATES+1 cycles after the acceptance edge and hold, with rsp_rdata/rsp_err stable, until rsp_valid&&rsp_ready; the block SHALL then return to IDLE.
REQ-019 Back-to-back throughput SHALL be one request per WAIT_STATES+2 cycles when rsp_ready is held high.
REQ-020 Loads: 000 LB SHALL sign-extend byte addr[1:0]; 100 LBU SHALL zero-extend it; 001 LH SHALL sign-extend halfword addr[1]; 101 LHU SHALL zero-extend it; 010 LW SHALL return the full word.
REQ-021 Stores: 000 SB SHALL write wdata[7:0] to lane addr[1:0]; 001 SH SHALL write wdata[15:0] to halfword addr[1]; 010 SW SHALL write the full word; other lanes SHALL remain unchanged.
REQ-022 rsp_err SHALL be 1 when any of these hold: halfword access with addr[0]=1; word access with addr[1:0]≠0; addr[31:2]≥DEPTH_WORDS; funct3 011/110/111; or funct3 1xx with we=1.
REQ-023 An errored request SHALL NOT write memory and SHALL return rsp_rdata=0.
REQ-024 Store commit SHALL occur exactly once, on the edge entering RESP.
REQ-025 req_valid while not in IDLE SHALL be ignored.
REQ-026 rsp_rdata and rsp_err SHALL be registered outputs.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 A store not yet committed when rst asserts SHALL be dropped.
REQ-030 req_ready SHALL be 1 on the first edge after rst deasserts.

Structure
REQ-031 Package dmem_pkg SHALL hold the funct3 constants (LB..LHU, SB..SW) and the FSM state encoding.
REQ-032 Storage SHALL be sub-module dmem_array: DEPTH_WORDS×32 with synchronous write, 4-bit byte enable and asynchronous read.
REQ-033 The FSM, error check and lane/extension logic SHALL reside in dmem_responder.

Verification
REQ-034 WAIT_STATES=1, SW 0xDEADBEEF @0x10 then LW @0x10 -> rsp_valid 2 cycles after each acceptance, rdata=0xDEADBEEF, err=0.
REQ-035 After REQ-034: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-036 SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF.
REQ-037 LW @0x12, SH @0x11 and LW @0x1000 (DEPTH_WORDS=1024) -> err=1, rdata=0; following LW @0x10 -> 0xDEAD55EF unchanged.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable; req_ready=0 throughout; new req_valid ignored.
REQ-039 rst pulsed during WAIT of SW 0x12345678 @0x20 (WAIT_STATES=3) -> outputs zero immediately; LW @0x20 afterwards returns the prior contents.
